// File: rtl/filter_pkg.sv
// Shared types and defaults for the 3x3 window filter sequencer.
package filter_pkg;

  // Sequencer states: one window fetch, FILT_LAT filter cycles and one write per pixel
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FILTER = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } seq_state_t;

  localparam int DEF_IMG_W    = 64;
  localparam int DEF_IMG_H    = 64;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_FILT_LAT = 2;

  // Number of pixel centres that have a full 3x3 neighbourhood inside the frame
  function automatic int interiorPixels(input int w, input int h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster walker over interior pixel centres: columns 1..IMG_W-2, rows 1..IMG_H-2.
module pixel_coord_counter
  import filter_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              last
);

  localparam logic [ADDR_W-1:0] FIRST    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 2);

  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;

  // Advance one centre per inc, wrapping the column and stepping the row at the right border
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= FIRST;
      r_col <= FIRST;
    end else if (clr) begin
      r_row <= FIRST;
      r_col <= FIRST;
    end else if (inc) begin
      if (r_col == COL_LAST) begin
        r_col <= FIRST;
        r_row <= r_row + FIRST;
      end else begin
        r_col <= r_col + FIRST;
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign last = (r_row == ROW_LAST) && (r_col == COL_LAST);

endmodule

// File: rtl/filter_sequencer.sv
// Frame sequencer for the 3x3 window filter: fetch window, run filter, write result.
module filter_sequencer
  import filter_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int FILT_LAT = DEF_FILT_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic              rd_ack,
  output logic              rd,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              act,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(FILT_LAT - 1);

  seq_state_t r_state;
  seq_state_t w_next;
  logic [CNT_W-1:0] r_lat;
  logic w_inc;
  logic w_clr;
  logic w_last;
  logic w_fetchAck;

  // A window is accepted only while the fetch request is actually being presented
  assign w_fetchAck = (r_state == S_FETCH) && en && rd_ack;

  pixel_coord_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_coord (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc),
    .clr   (w_clr),
    .row   (row),
    .col   (col),
    .last  (w_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and coordinate control; abort overrides every other transition
  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    w_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && en) begin
          w_next = S_FETCH;
          w_clr  = 1'b1;
        end
      end
      S_FETCH: begin
        if (w_fetchAck) w_next = S_FILTER;
      end
      S_FILTER: begin
        if (r_lat == '0) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (w_last) begin
          w_next = S_FINISH;
        end else begin
          w_next = S_FETCH;
          w_inc  = 1'b1;
        end
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort) begin
      w_next = S_IDLE;
      w_inc  = 1'b0;
      w_clr  = 1'b1;
    end
  end

  // Filter latency counter: loaded on window accept, counts down through FILTER
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat <= '0;
    end else if (abort) begin
      r_lat <= '0;
    end else if (w_fetchAck) begin
      r_lat <= LAT_LOAD;
    end else if ((r_state == S_FILTER) && (r_lat != '0)) begin
      r_lat <= r_lat - CNT_W'(1);
    end
  end

  assign rd      = (r_state == S_FETCH) && en;
  assign act     = (r_state == S_FILTER);
  assign wr      = (r_state == S_WRITE);
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_FINISH);
  assign wr_addr = wr ? (row * ADDR_W'(IMG_W) + col) : '0;

endmodule

// File: tb/tb_filter_sequencer.sv
// Self-checking bench: a 4x4 and a 3x3 sequencer driven by directed and random frames.
module tb_filter_sequencer;

  localparam int LAT = 2;
  localparam int AW  = 12;

  logic clk = 1'b0;
  logic rst_n, en, startA, startB, abort, rd_ack;
  logic rdA, actA, wrA, busyA, doneA;
  logic rdB, actB, wrB, busyB, doneB;
  logic [AW-1:0] rowA, colA, addrA, rowB, colB, addrB;
  logic sel;
  logic oRd, oAct, oWr, oBusy, oDone;
  logic [AW-1:0] oRow, oCol, oAddr;

  int total = 0;
  int bad = 0;
  int ackDelay[$];

  always #5 clk = ~clk;

  filter_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW), .FILT_LAT(LAT)) dutA (
    .clk(clk), .rst_n(rst_n), .en(en), .start(startA), .abort(abort), .rd_ack(rd_ack),
    .rd(rdA), .row(rowA), .col(colA), .act(actA), .wr(wrA), .wr_addr(addrA),
    .busy(busyA), .done(doneA)
  );

  filter_sequencer #(.IMG_W(3), .IMG_H(3), .ADDR_W(AW), .FILT_LAT(LAT)) dutB (
    .clk(clk), .rst_n(rst_n), .en(en), .start(startB), .abort(abort), .rd_ack(rd_ack),
    .rd(rdB), .row(rowB), .col(colB), .act(actB), .wr(wrB), .wr_addr(addrB),
    .busy(busyB), .done(doneB)
  );

  // Observe whichever instance the current step is exercising
  assign oRd   = sel ? rdB   : rdA;
  assign oAct  = sel ? actB  : actA;
  assign oWr   = sel ? wrB   : wrA;
  assign oBusy = sel ? busyB : busyA;
  assign oDone = sel ? doneB : doneA;
  assign oRow  = sel ? rowB  : rowA;
  assign oCol  = sel ? colB  : colA;
  assign oAddr = sel ? addrB : addrA;

  // One comparison: count it, and report tag/observed/expected when it misses
  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Run one frame from a start pulse; rd_ack follows ackDelay, optional abort and stray start
  task automatic applyStimulus(input bit useSmall, input int abortAddr, input int spurCyc);
    int w, h, pix, expDone, cyc, pixIdx, rdRun, actRun, quietBusy, quietWr, quietDone;
    int expAddr[$];
    bit finished, aborted;
    sel = useSmall;
    w = useSmall ? 3 : 4;
    h = useSmall ? 3 : 4;
    for (int r = 1; r <= h - 2; r++)
      for (int c = 1; c <= w - 2; c++)
        expAddr.push_back(r * w + c);
    pix = expAddr.size();
    expDone = pix * (LAT + 2) + 1;
    for (int i = 0; i < pix; i++) expDone += ackDelay[i];
    @(negedge clk);
    en = 1'b1;
    if (useSmall) startB = 1'b1; else startA = 1'b1;
    @(negedge clk);
    cyc = 1; pixIdx = 0; rdRun = 0; actRun = 0; finished = 0; aborted = 0;
    while (!finished && cyc < 400) begin
      startA = 1'b0; startB = 1'b0; rd_ack = 1'b0; abort = 1'b0;
      checkOutput("one_hot", int'((int'(oRd) + int'(oAct) + int'(oWr)) <= 1), 1);
      if (oRd && pixIdx < pix) begin
        checkOutput("fetch_centre", int'(oRow) * w + int'(oCol), expAddr[pixIdx]);
        if (rdRun == ackDelay[pixIdx]) rd_ack = 1'b1;
        rdRun++;
      end
      if (oAct) actRun++;
      if (oWr) begin
        checkOutput("wr_addr", int'(oAddr), (pixIdx < pix) ? expAddr[pixIdx] : -1);
        if (pixIdx < pix) checkOutput("rd_hold", rdRun, ackDelay[pixIdx] + 1);
        checkOutput("act_len", actRun, LAT);
        if (int'(oAddr) == abortAddr) begin
          abort = 1'b1; aborted = 1; finished = 1;
        end
        pixIdx++; rdRun = 0; actRun = 0;
      end
      if (oDone) begin
        checkOutput("done_cycle", cyc, expDone);
        checkOutput("pixel_count", pixIdx, pix);
        finished = 1;
      end
      if (cyc == spurCyc) begin
        if (useSmall) startB = 1'b1; else startA = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    startA = 1'b0; startB = 1'b0; rd_ack = 1'b0; abort = 1'b0;
    if (!finished) checkOutput("frame_timeout", cyc, expDone);
    checkOutput("busy_after", int'(oBusy), 0);
    checkOutput("done_after", int'(oDone), 0);
    quietBusy = 0; quietWr = 0; quietDone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      quietBusy += int'(oBusy);
      quietWr   += int'(oWr);
      quietDone += int'(oDone);
    end
    checkOutput("quiet_busy", quietBusy, 0);
    checkOutput("quiet_wr", quietWr, 0);
    checkOutput("quiet_done", quietDone, aborted ? 0 : 0);
  endtask

  initial begin
    int waitCyc, nAct, nWr, nRd, wrAddrSeen, rdAfter, busyCnt;
    rst_n = 1'b0; en = 1'b0; startA = 1'b0; startB = 1'b0; abort = 1'b0; rd_ack = 1'b0;
    sel = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_rd", int'(rdA), 0);
    checkOutput("rst_act", int'(actA), 0);
    checkOutput("rst_wr", int'(wrA), 0);
    checkOutput("rst_busy", int'(busyA), 0);
    checkOutput("rst_done", int'(doneA), 0);
    checkOutput("rst_row", int'(rowA), 1);
    checkOutput("rst_col", int'(colA), 1);
    checkOutput("rst_wr_addr", int'(addrA), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame with immediate acknowledge
    ackDelay = '{0, 0, 0, 0};
    applyStimulus(1'b0, -1, -1);

    // Acknowledge delayed three cycles on the second pixel
    ackDelay = '{0, 3, 0, 0};
    applyStimulus(1'b0, -1, -1);

    // Abort during the write of pixel 3, then a fresh frame from the first centre
    ackDelay = '{0, 0, 0, 0};
    applyStimulus(1'b0, 9, -1);
    applyStimulus(1'b0, -1, -1);

    // Start pulsed mid-frame must not queue a second frame
    applyStimulus(1'b0, -1, 6);

    // Start with enable low is ignored
    sel = 1'b0;
    @(negedge clk);
    en = 1'b0; startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    busyCnt = 0;
    for (int i = 0; i < 4; i++) begin
      busyCnt += int'(busyA);
      @(negedge clk);
    end
    checkOutput("start_en_low", busyCnt, 0);

    // Enable dropped during FILTER of pixel 1: write completes, fetch pauses
    en = 1'b1; rd_ack = 1'b1; startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    waitCyc = 0;
    while (!actA && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("pause_act_seen", int'(actA), 1);
    en = 1'b0;
    nAct = 0; nWr = 0; nRd = 0; wrAddrSeen = -1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nAct += int'(actA);
      nRd  += int'(rdA);
      if (wrA) begin
        nWr++;
        wrAddrSeen = int'(addrA);
      end
    end
    checkOutput("pause_act", nAct, 1);
    checkOutput("pause_wr", nWr, 1);
    checkOutput("pause_wr_addr", wrAddrSeen, 5);
    checkOutput("pause_rd", nRd, 0);
    en = 1'b1;
    #1;
    rdAfter = int'(rdA);
    checkOutput("resume_rd", rdAfter, 1);
    checkOutput("resume_centre", int'(rowA) * 4 + int'(colA), 6);
    waitCyc = 0;
    nWr = 0;
    @(negedge clk);
    while (!doneA && waitCyc < 100) begin
      nWr += int'(wrA);
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("resume_done", int'(doneA), 1);
    checkOutput("resume_writes", nWr, 3);
    rd_ack = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of FILTER
    rd_ack = 1'b1; startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    waitCyc = 0;
    while (!actA && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("mid_act_seen", int'(actA), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_act", int'(actA), 0);
    checkOutput("async_busy", int'(busyA), 0);
    checkOutput("async_rd", int'(rdA), 0);
    checkOutput("async_wr", int'(wrA), 0);
    checkOutput("async_row", int'(rowA), 1);
    checkOutput("async_col", int'(colA), 1);
    rd_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Smallest legal frame: one interior pixel at address 4
    ackDelay = '{0};
    applyStimulus(1'b1, -1, -1);

    // Random acknowledge latencies and stray start pulses
    for (int k = 0; k < 5; k++) begin
      ackDelay.delete();
      for (int i = 0; i < 4; i++) ackDelay.push_back(int'($urandom_range(0, 3)));
      applyStimulus(1'b0, -1, int'($urandom_range(2, 20)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_sequencer.md
Name: filter_sequencer

Overview:
- Sequences the 3x3 window filter datapath over one image frame.
- Walks interior pixel centres in raster order and, for each centre, requests a window fetch from pixel memory.
- Enables the filter for its pipeline latency, then issues one write of the filtered pixel.
- Sits between the top-level start/enable controls and the memory/filter pair; replaces the free-running read/activate handshake with a counted, addressed one.

Parameters:
- IMG_W, 64, image width in pixels (>=3)
- IMG_H, 64, image height in pixels (>=3)
- ADDR_W, 12, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- FILT_LAT, 2, filter pipeline latency in cycles (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low pauses at the next pixel boundary
- start  in  1  single-cycle frame start request
- abort  in  1  single-cycle abort; returns to IDLE
- rd_ack  in  1  memory has presented the 3x3 window for the current centre
- rd  out  1  window fetch request; held until rd_ack
- row  out  ADDR_W  current centre row
- col  out  ADDR_W  current centre column
- act  out  1  filter enable, high for exactly FILT_LAT cycles per pixel
- wr  out  1  write strobe for the filtered pixel, one cycle
- wr_addr  out  ADDR_W  row*IMG_W+col, valid while wr=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last write of a frame

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - rd, act, wr, busy, done = 0.
  - row = col = 1; wr_addr = 0; latency counter = 0.
- States: IDLE, FETCH, FILTER, WRITE, FINISH.
- IDLE:
  - start=1 and en=1 -> FETCH next cycle, with row=1, col=1.
  - start while en=0, or start while busy: ignored (not queued).
- FETCH:
  - rd=1 while en=1; rd=0 while en=0 (paused).
  - rd_ack=1 with rd=1 -> FILTER next cycle and latency counter loaded with FILT_LAT-1.
  - rd_ack while rd=0 is ignored.
- FILTER:
  - act=1; counter decrements each cycle.
  - Counter at 0 -> WRITE next cycle.
  - en is ignored here; a pixel in flight always completes.
- WRITE:
  - wr=1 for one cycle; wr_addr = row*IMG_W+col, computed combinationally from the registered row/col.
  - Next cycle: if col==IMG_W-2 and row==IMG_H-2 -> FINISH.
  - Else if col==IMG_W-2 -> col=1, row=row+1, FETCH.
  - Else col=col+1, FETCH.
- FINISH: done=1 for one cycle -> IDLE; busy=0 from the IDLE cycle onward.
- Border pixels (row or col equal to 0 or max) are never visited. Pixels per frame = (IMG_W-2)*(IMG_H-2).
- Latency per pixel with immediate rd_ack = FILT_LAT+2 cycles. Frame = pixels*(FILT_LAT+2)+1 cycles from the first FETCH through done.
- abort=1 in any state:
  - -> IDLE next cycle.
  - rd, act, wr drop; no done pulse; row/col reset to 1.
  - abort has priority over every other transition, including completion in WRITE and start in IDLE.
- Only one of rd, act, wr is ever high in a given cycle.
- start during FINISH is ignored.

Decomposition:
- filter_pkg holds:
  - the state enum;
  - IMG_W/IMG_H/ADDR_W defaults;
  - the constant function for the interior pixel count.
- Sub-module pixel_coord_counter implements the row/col raster walker:
  - inputs: inc, clr;
  - outputs: row, col, last;
  - last = (row==IMG_H-2 && col==IMG_W-2).
- The FSM and latency counter stay in filter_sequencer.

Test Plan:
- IMG_W=4, IMG_H=4, FILT_LAT=2, rd_ack tied high, en=1, start pulse -> wr_addr sequence 5,6,9,10; act high 2 cycles before each wr; done pulses exactly 17 cycles after start; busy then 0.
- Same config, rd_ack delayed 3 cycles on pixel 2 -> rd held high 4 cycles on that pixel, row/col stable (1,2); no act until the cycle after ack; total to done = 20 cycles.
- en dropped during FILTER of pixel 1 and raised 5 cycles later -> pixel 1 write (addr 5) completes; rd stays 0 while paused; pixel 2 fetch begins when en returns.
- abort asserted in the WRITE cycle of pixel 3 (addr 9) -> next cycle IDLE, no done, no further wr; a new start gives the sequence from addr 5 again.
- start pulsed while busy and start with en=0 -> no state change and no second frame; reset asserted mid-FILTER -> all outputs 0 immediately (asynchronous), row=col=1.
- IMG_W=3, IMG_H=3 -> exactly one wr, at addr 4; done is asserted.
